mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive denied cycles before requester 0 is promoted (range 1..15).
REQ-002 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 Port Nrst, input, 1: asynchronous, active-low reset.
REQ-004 Ports r0_addr/r1_addr, input, 32: requester byte address. Requester 0 is instruction fetch; requester 1 is the memory stage.
REQ-005 Ports r0_rd_req/r1_rd_req and r0_wr_req/r1_wr_req, input, 1 each: read and write request strobes.
REQ-006 Ports r0_wr_data/r1_wr_data, input, 32: store data.
REQ-007 Port r1_lock, input, 1: requester 1 holds the bus across back-to-back transfers (LDM/STM burst).
REQ-008 Ports r0_rd_data/r1_rd_data, output, 32: broadcast copy of rd_data.
REQ-009 Ports r0_wait/r1_wait, output, 1: per-requester stall.
REQ-010 Ports r0_gnt/r1_gnt, output, 1: requester owns the bus this cycle.
REQ-011 Ports busaddr (output, 32), rd_req (output, 1), wr_req (output, 1), wr_data (output, 32), rd_data (input, 32), rw_wait (input, 1): downstream memory bus.

Function
REQ-012 The state machine has five states: IDLE, BUSY0, BUSY1, LOCK1, PARK.
- PARK is entered only via reset.
- PARK goes to IDLE on the first clock edge after reset deasserts.
REQ-013 In IDLE, the grant is combinational in the same cycle, with zero added latency.
- Base priority: requester 1 over requester 0.
- Requester 0 is granted only when requester 1 does not request, unless the starvation rule (REQ-024) applies.
REQ-014 In BUSY0, the grant is held on requester 0 regardless of other requests. BUSY1 and LOCK1 hold the grant on requester 1 in the same way.
REQ-015 The granted requester's addr, rd_req, wr_req and wr_data drive the bus combinationally.
- With no grant, rd_req=wr_req=0.
- With no grant, busaddr and wr_data are 0.
REQ-016 Wait signals:
- The granted requester's wait equals rw_wait.
- A requesting, non-granted requester sees wait=1.
- A non-requesting requester sees wait=0.
REQ-017 State transitions from IDLE and BUSYx, at the clock edge:
- Granted requester x active with rw_wait=1 -> BUSYx.
- Requester 1 granted, r1_lock=1 and rw_wait=0 -> LOCK1.
- Otherwise -> IDLE.
REQ-018 Abort: in BUSYx, if requester x drops both rd_req and wr_req, the grant is released.
- Bus strobes go to 0 in the same cycle.
- The next state is IDLE.
REQ-019 LOCK1 remains while r1_lock=1 or rw_wait=1, and exits to IDLE otherwise. Requester 0 cannot be granted while in LOCK1.
REQ-020 Simultaneous rd_req and wr_req from one requester: the request is forwarded unchanged. The arbiter does not check it.
REQ-021 r1_lock asserted without rd_req/wr_req has no effect in IDLE.
REQ-022 r0_gnt and r1_gnt are never both 1. r0_gnt=1 implies r1_wait=1 if requester 1 requests, and vice versa.
REQ-023 The starvation counter starve0 is 4 bits and saturates at 15.
- Increments each edge where requester 0 requests and is denied.
- Clears to 0 when requester 0 is granted or not requesting.

Configuration
REQ-024 Macro ARB_STARVE_EN, when defined, adds starvation promotion:
- In IDLE with starve0 >= STARVE_LIMIT, requester 0 wins over requester 1.
- LOCK1 and BUSY1 are never pre-empted.
- Without the macro, the starve0 register is absent and priority is strictly fixed: requester 1 over requester 0.

Reset
REQ-025 While Nrst=0, independent of clk:
- State is PARK and starve0=0.
- r0_gnt=r1_gnt=0, rd_req=wr_req=0, busaddr=0, wr_data=0.
- r0_wait=r1_wait=1.
REQ-026 Reset asserted mid-transfer, including in BUSYx or LOCK1:
- Strobes drop immediately.
- No pending state survives.
- After release, the first grant occurs no earlier than the second edge.

Verification
REQ-027 Only r0 reads 0x100, rw_wait=0: same cycle r0_gnt=1, rd_req=1, busaddr=0x100, r0_wait=0, and the next state is IDLE.
REQ-028 Both request in IDLE, rw_wait=1 for 3 cycles: r1 is granted, state is BUSY1 for 3 cycles with r0_wait=1, then r0 is granted on the following cycle.
REQ-029 Grant given to r0, then r1 requests while rw_wait=1: r0 keeps the grant until rw_wait=0 and r1_wait stays 1. Then r0 drops its request and r1 is granted.
REQ-030 r1 STM burst of 4 words with r1_lock=1 and r0 requesting throughout: LOCK1 holds and r0_gnt=0. After r1_lock falls and rw_wait=0, r0 is granted next cycle.
REQ-031 ARB_STARVE_EN defined, STARVE_LIMIT=4, r1 issues continuous single unlocked reads, r0 requests: r0 is granted on the cycle starve0 reaches 4, and starve0 clears. Without the macro, r0 is never granted.
REQ-032 Nrst pulsed low during BUSY1: immediately rd_req=0 and both waits are 1. Edge 1 after release is PARK->IDLE; a grant occurs on edge 2.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter (r0 = instruction fetch, r1 = memory stage).
// Optional macro ARB_STARVE_EN adds starvation promotion of requester 0.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        Nrst,
    input  logic [31:0] r0_addr,
    input  logic        r0_rd_req,
    input  logic        r0_wr_req,
    input  logic [31:0] r0_wr_data,
    output logic [31:0] r0_rd_data,
    output logic        r0_wait,
    output logic        r0_gnt,
    input  logic [31:0] r1_addr,
    input  logic        r1_rd_req,
    input  logic        r1_wr_req,
    input  logic [31:0] r1_wr_data,
    input  logic        r1_lock,
    output logic [31:0] r1_rd_data,
    output logic        r1_wait,
    output logic        r1_gnt,
    output logic [31:0] busaddr,
    output logic        rd_req,
    output logic        wr_req,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    input  logic        rw_wait,
    output logic [2:0]  o_dbg_state,
    output logic [3:0]  o_dbg_starve0
);

    // Handshake: a requester's transfer completes on the rising edge where it
    // sees gnt=1 and wait=0; while wait=1 it holds addr, strobes and data stable.

    typedef enum logic [2:0] {
        S_PARK  = 3'd0,
        S_IDLE  = 3'd1,
        S_BUSY0 = 3'd2,
        S_BUSY1 = 3'd3,
        S_LOCK1 = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_r0_act;
    logic   w_r1_act;
    logic   w_gnt0;
    logic   w_gnt1;
    logic   w_promote0;

    assign w_r0_act = r0_rd_req | r0_wr_req;
    assign w_r1_act = r1_rd_req | r1_wr_req;

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            r_state <= S_PARK;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_PARK: w_next_state = S_IDLE;
            S_IDLE, S_BUSY0, S_BUSY1: begin
                if (w_gnt0 && rw_wait) begin
                    w_next_state = S_BUSY0;
                end else if (w_gnt1 && rw_wait) begin
                    w_next_state = S_BUSY1;
                end else if (w_gnt1 && r1_lock) begin
                    w_next_state = S_LOCK1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOCK1: w_next_state = (r1_lock || rw_wait) ? S_LOCK1 : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Grants are combinational so an IDLE request is served in its own cycle.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_promote0) begin
                    w_gnt0 = 1'b1;
                end else if (w_r1_act) begin
                    w_gnt1 = 1'b1;
                end else if (w_r0_act) begin
                    w_gnt0 = 1'b1;
                end
            end
            S_BUSY0: w_gnt0 = w_r0_act;
            S_BUSY1: w_gnt1 = w_r1_act;
            S_LOCK1: w_gnt1 = 1'b1;
            default: begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        endcase

        busaddr = 32'd0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        wr_data = 32'd0;
        if (w_gnt0) begin
            busaddr = r0_addr;
            rd_req  = r0_rd_req;
            wr_req  = r0_wr_req;
            wr_data = r0_wr_data;
        end else if (w_gnt1) begin
            busaddr = r1_addr;
            rd_req  = r1_rd_req;
            wr_req  = r1_wr_req;
            wr_data = r1_wr_data;
        end

        r0_gnt     = w_gnt0;
        r1_gnt     = w_gnt1;
        r0_wait    = !Nrst || (w_gnt0 ? rw_wait : w_r0_act);
        r1_wait    = !Nrst || (w_gnt1 ? rw_wait : w_r1_act);
        r0_rd_data = rd_data;
        r1_rd_data = rd_data;
    end

    assign o_dbg_state = r_state;

`ifdef ARB_STARVE_EN
    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve0;

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            r_starve0 <= 4'd0;
        end else if (w_r0_act && !w_gnt0) begin
            if (r_starve0 != 4'd15) begin
                r_starve0 <= r_starve0 + 4'd1;
            end
        end else begin
            r_starve0 <= 4'd0;
        end
    end

    // Promotion only matters in IDLE; BUSY1/LOCK1 ignore it by construction.
    assign w_promote0    = w_r0_act && (r_starve0 >= LP_LIMIT);
    assign o_dbg_starve0 = r_starve0;
`else
    assign w_promote0    = 1'b0;
    assign o_dbg_starve0 = 4'd0;
`endif

    a_limit_range: assert property (@(posedge clk)
        (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15));

    a_gnt_exclusive: assert property (@(posedge clk) disable iff (!Nrst)
        !(r0_gnt && r1_gnt));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (STARVE_LIMIT=4); the
// starvation section follows whichever ARB_STARVE_EN build is compiled.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam logic [31:0] ST_PARK  = 32'd0;
    localparam logic [31:0] ST_IDLE  = 32'd1;
    localparam logic [31:0] ST_BUSY0 = 32'd2;
    localparam logic [31:0] ST_BUSY1 = 32'd3;
    localparam logic [31:0] ST_LOCK1 = 32'd4;

    logic        clk = 1'b0;
    logic        Nrst;
    logic [31:0] r0_addr, r0_wr_data, r0_rd_data;
    logic        r0_rd_req, r0_wr_req, r0_wait, r0_gnt;
    logic [31:0] r1_addr, r1_wr_data, r1_rd_data;
    logic        r1_rd_req, r1_wr_req, r1_lock, r1_wait, r1_gnt;
    logic [31:0] busaddr, wr_data, rd_data;
    logic        rd_req, wr_req, rw_wait;
    logic [2:0]  dbg_state;
    logic [3:0]  dbg_starve0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          hits;
    logic        sb_on = 1'b0;
    logic [31:0] exp_q[$];

    mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .Nrst(Nrst),
        .r0_addr(r0_addr), .r0_rd_req(r0_rd_req), .r0_wr_req(r0_wr_req),
        .r0_wr_data(r0_wr_data), .r0_rd_data(r0_rd_data), .r0_wait(r0_wait), .r0_gnt(r0_gnt),
        .r1_addr(r1_addr), .r1_rd_req(r1_rd_req), .r1_wr_req(r1_wr_req),
        .r1_wr_data(r1_wr_data), .r1_lock(r1_lock), .r1_rd_data(r1_rd_data),
        .r1_wait(r1_wait), .r1_gnt(r1_gnt),
        .busaddr(busaddr), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
        .rd_data(rd_data), .rw_wait(rw_wait),
        .o_dbg_state(dbg_state), .o_dbg_starve0(dbg_starve0)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_addr = 32'd0; r0_rd_req = 1'b0; r0_wr_req = 1'b0; r0_wr_data = 32'd0;
        r1_addr = 32'd0; r1_rd_req = 1'b0; r1_wr_req = 1'b0; r1_wr_data = 32'd0;
        r1_lock = 1'b0;  rw_wait = 1'b0;
    endtask

    // Scoreboard: every completed bus transfer inside a scored window pops one address.
    always @(negedge clk) begin
        if (sb_on && Nrst && (rd_req || wr_req) && !rw_wait) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                check_eq("sb_addr", busaddr, exp_q.pop_front());
            end
        end
    end

    initial begin
        Nrst = 1'b0;
        rd_data = 32'd0;
        clear_inputs();
        r0_rd_req = 1'b1; r0_addr = 32'h200;
        r1_wr_req = 1'b1; r1_addr = 32'h300; r1_wr_data = 32'h1234;
        step();
        step();
        check_eq("rst_gnt0",  32'(r0_gnt),  32'd0);
        check_eq("rst_gnt1",  32'(r1_gnt),  32'd0);
        check_eq("rst_rd",    32'(rd_req),  32'd0);
        check_eq("rst_wr",    32'(wr_req),  32'd0);
        check_eq("rst_addr",  busaddr,      32'd0);
        check_eq("rst_wdata", wr_data,      32'd0);
        check_eq("rst_wait0", 32'(r0_wait), 32'd1);
        check_eq("rst_wait1", 32'(r1_wait), 32'd1);
        check_eq("rst_state", 32'(dbg_state), ST_PARK);
        check_eq("rst_starve", 32'(dbg_starve0), 32'd0);
        clear_inputs();
        Nrst = 1'b1;
        #1;
        check_eq("park_hold", 32'(dbg_state), ST_PARK);
        step();
        check_eq("park_exit", 32'(dbg_state), ST_IDLE);

        // Lone r0 read, zero wait
        r0_rd_req = 1'b1; r0_addr = 32'h100; rd_data = 32'hDEADBEEF;
        #1;
        check_eq("solo_gnt0",  32'(r0_gnt),  32'd1);
        check_eq("solo_gnt1",  32'(r1_gnt),  32'd0);
        check_eq("solo_rd",    32'(rd_req),  32'd1);
        check_eq("solo_wr",    32'(wr_req),  32'd0);
        check_eq("solo_addr",  busaddr,      32'h100);
        check_eq("solo_wait0", 32'(r0_wait), 32'd0);
        check_eq("solo_wait1", 32'(r1_wait), 32'd0);
        check_eq("solo_rdat0", r0_rd_data,   32'hDEADBEEF);
        check_eq("solo_rdat1", r1_rd_data,   32'hDEADBEEF);
        step();
        check_eq("solo_next", 32'(dbg_state), ST_IDLE);
        clear_inputs();

        // r1_lock without a request must not enter LOCK1
        r1_lock = 1'b1; r0_rd_req = 1'b1; r0_addr = 32'h104;
        #1;
        check_eq("lkonly_gnt0", 32'(r0_gnt), 32'd1);
        step();
        check_eq("lkonly_state", 32'(dbg_state), ST_IDLE);
        clear_inputs();

        // Both request, r1 wins and stalls three cycles
        r0_rd_req = 1'b1; r0_addr = 32'h100;
        r1_wr_req = 1'b1; r1_addr = 32'h300; r1_wr_data = 32'hA5A50001; rw_wait = 1'b1;
        #1;
        check_eq("both_gnt1",  32'(r1_gnt),  32'd1);
        check_eq("both_gnt0",  32'(r0_gnt),  32'd0);
        check_eq("both_wait0", 32'(r0_wait), 32'd1);
        check_eq("both_wait1", 32'(r1_wait), 32'd1);
        check_eq("both_addr",  busaddr,      32'h300);
        check_eq("both_wr",    32'(wr_req),  32'd1);
        check_eq("both_rd",    32'(rd_req),  32'd0);
        check_eq("both_wdata", wr_data,      32'hA5A50001);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) rw_wait = 1'b0;
            #1;
            check_eq("busy1_state", 32'(dbg_state), ST_BUSY1);
            check_eq("busy1_gnt1",  32'(r1_gnt),    32'd1);
            check_eq("busy1_wait0", 32'(r0_wait),   32'd1);
            check_eq("busy1_wait1", 32'(r1_wait),   (i == 2) ? 32'd0 : 32'd1);
        end
        step();
        r1_wr_req = 1'b0;
        #1;
        check_eq("after1_state", 32'(dbg_state), ST_IDLE);
        check_eq("after1_gnt0",  32'(r0_gnt),    32'd1);
        check_eq("after1_gnt1",  32'(r1_gnt),    32'd0);
        check_eq("after1_addr",  busaddr,        32'h100);
        check_eq("after1_rd",    32'(rd_req),    32'd1);
        check_eq("after1_wait0", 32'(r0_wait),   32'd0);
        step();
        clear_inputs();

        // r0 holds through r1's request while rw_wait=1
        r0_rd_req = 1'b1; r0_addr = 32'h104; rw_wait = 1'b1;
        #1;
        check_eq("hold_a_gnt0", 32'(r0_gnt), 32'd1);
        step();
        r1_rd_req = 1'b1; r1_addr = 32'h400;
        #1;
        check_eq("hold_state", 32'(dbg_state), ST_BUSY0);
        check_eq("hold_gnt0",  32'(r0_gnt),    32'd1);
        check_eq("hold_gnt1",  32'(r1_gnt),    32'd0);
        check_eq("hold_wait1", 32'(r1_wait),   32'd1);
        check_eq("hold_addr",  busaddr,        32'h104);
        step();
        rw_wait = 1'b0;
        #1;
        check_eq("hold_done_gnt0",  32'(r0_gnt),  32'd1);
        check_eq("hold_done_wait0", 32'(r0_wait), 32'd0);
        check_eq("hold_done_wait1", 32'(r1_wait), 32'd1);
        step();
        r0_rd_req = 1'b0;
        #1;
        check_eq("hand_state", 32'(dbg_state), ST_IDLE);
        check_eq("hand_gnt1",  32'(r1_gnt),    32'd1);
        check_eq("hand_addr",  busaddr,        32'h400);
        check_eq("hand_wait1", 32'(r1_wait),   32'd0);
        step();
        clear_inputs();

        // Abort: r0 drops its request while in BUSY0
        r0_rd_req = 1'b1; r0_addr = 32'h108; rw_wait = 1'b1;
        step();
        r0_rd_req = 1'b0; r1_rd_req = 1'b1; r1_addr = 32'h40C; rw_wait = 1'b0;
        #1;
        check_eq("abort_state", 32'(dbg_state), ST_BUSY0);
        check_eq("abort_gnt0",  32'(r0_gnt),    32'd0);
        check_eq("abort_gnt1",  32'(r1_gnt),    32'd0);
        check_eq("abort_rd",    32'(rd_req),    32'd0);
        check_eq("abort_addr",  busaddr,        32'd0);
        check_eq("abort_wait1", 32'(r1_wait),   32'd1);
        check_eq("abort_wait0", 32'(r0_wait),   32'd0);
        step();
        check_eq("abort_next",  32'(dbg_state), ST_IDLE);
        check_eq("abort_regnt", 32'(r1_gnt),    32'd1);
        step();
        clear_inputs();

        // Locked 4-word STM burst with r0 waiting throughout
        sb_on = 1'b1;
        r0_rd_req = 1'b1; r0_addr = 32'h700; r1_wr_req = 1'b1; r1_lock = 1'b1;
        for (int w = 0; w < 4; w++) begin
            r1_addr    = 32'h500 + 32'(w * 4);
            r1_wr_data = 32'(w + 1);
            if (w == 3) r1_lock = 1'b0;
            exp_q.push_back(32'h500 + 32'(w * 4));
            #1;
            check_eq("burst_state", 32'(dbg_state), (w == 0) ? ST_IDLE : ST_LOCK1);
            check_eq("burst_gnt0",  32'(r0_gnt),    32'd0);
            check_eq("burst_gnt1",  32'(r1_gnt),    32'd1);
            check_eq("burst_wait0", 32'(r0_wait),   32'd1);
            check_eq("burst_addr",  busaddr,        32'h500 + 32'(w * 4));
            check_eq("burst_wdata", wr_data,        32'(w + 1));
            step();
        end
        r1_wr_req = 1'b0;
        exp_q.push_back(32'h700);
        #1;
        check_eq("post_state", 32'(dbg_state), ST_IDLE);
        check_eq("post_gnt0",  32'(r0_gnt),    32'd1);
        check_eq("post_addr",  busaddr,        32'h700);
        step();
        sb_on = 1'b0;
        clear_inputs();
        step();

        // r1 streams unlocked single reads while r0 keeps requesting
        r1_rd_req = 1'b1; r1_addr = 32'h800; r0_rd_req = 1'b1; r0_addr = 32'h900;
`ifdef ARB_STARVE_EN
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq("starve_cnt",  32'(dbg_starve0), 32'(c));
            check_eq("starve_deny", 32'(r0_gnt),      32'd0);
            step();
        end
        #1;
        check_eq("promote_cnt",   32'(dbg_starve0), 32'd4);
        check_eq("promote_gnt0",  32'(r0_gnt),      32'd1);
        check_eq("promote_gnt1",  32'(r1_gnt),      32'd0);
        check_eq("promote_wait1", 32'(r1_wait),     32'd1);
        check_eq("promote_addr",  busaddr,          32'h900);
        step();
        #1;
        check_eq("promote_clear", 32'(dbg_starve0), 32'd0);
        check_eq("promote_back1", 32'(r1_gnt),      32'd1);
`else
        hits = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (r0_gnt) hits++;
            step();
        end
        check_eq("strict_never_r0", 32'(hits), 32'd0);
        check_eq("strict_gnt1",     32'(r1_gnt), 32'd1);
        check_eq("strict_starve",   32'(dbg_starve0), 32'd0);
`endif
        clear_inputs();
        step();

        // Reset pulse in the middle of a BUSY1 transfer
        r1_rd_req = 1'b1; r1_addr = 32'h600; rw_wait = 1'b1;
        step();
        check_eq("mid_state", 32'(dbg_state), ST_BUSY1);
        Nrst = 1'b0;
        #1;
        check_eq("mid_rd",    32'(rd_req),    32'd0);
        check_eq("mid_gnt1",  32'(r1_gnt),    32'd0);
        check_eq("mid_wait0", 32'(r0_wait),   32'd1);
        check_eq("mid_wait1", 32'(r1_wait),   32'd1);
        check_eq("mid_addr",  busaddr,        32'd0);
        check_eq("mid_park",  32'(dbg_state), ST_PARK);
        rw_wait = 1'b0;
        step();
        Nrst = 1'b1;
        #1;
        check_eq("rel_state", 32'(dbg_state), ST_PARK);
        check_eq("rel_gnt1",  32'(r1_gnt),    32'd0);
        check_eq("rel_wait1", 32'(r1_wait),   32'd1);
        step();
        check_eq("edge1_state", 32'(dbg_state), ST_IDLE);
        check_eq("edge1_gnt1",  32'(r1_gnt),    32'd1);
        check_eq("edge1_rd",    32'(rd_req),    32'd1);
        step();
        check_eq("edge2_state", 32'(dbg_state), ST_IDLE);
        clear_inputs();
        step();

        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
